dmem_mmu_hs: RTL and testbench

- Second-generation byte-addressable data MMU for the embedded RV32I softcore; sits between the core's memory stage, the instruction ROM, the on-chip byte-lane RAM and the I/O bus.
- Adds over the first generation:
  - parametrised address map and RAM depth;
  - address-based byte-lane steering driven by an access size;
  - misaligned and unmapped access fault reporting;
  - a req/ack I/O handshake with stall and timeout.
- Instruction fetch path is a registered pass-through.

---
 rtl/dmem_mmu_hs.sv | 269 ++++++++++++++++++++++++++
 tb/tb_dmem_mmu_hs.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmu_hs.sv
// Data MMU for the RV32I softcore: RAM/I-O address decode, byte-lane steering,
// fault reporting and a req/ack I/O handshake with timeout; registered fetch pass-through.
module dmem_mmu_hs #(
   parameter logic [31:0] RAM_BASE      = 32'h1000_0000,
   parameter int          RAM_WORDS_LOG = 8,
   parameter logic [31:0] IO_BASE       = 32'h8000_0000,
   parameter int          IM_BYTES_LOG  = 12,
   parameter int          IO_TIMEOUT    = 15
) (
   input  logic                    clk,
   input  logic                    resetb,
   input  logic [31:0]             im_addr,
   output logic [IM_BYTES_LOG-3:0] im_addr_out,
   input  logic [31:0]             im_data,
   output logic [31:0]             im_do,
   input  logic                    dm_req,
   input  logic                    dm_we,
   input  logic [31:0]             dm_addr,
   input  logic [1:0]              dm_size,
   input  logic                    dm_signed,
   input  logic [31:0]             dm_di,
   output logic [31:0]             dm_do,
   output logic                    dm_valid,
   output logic [1:0]              dm_fault,
   output logic                    dm_stall,
   output logic                    io_req,
   output logic                    io_we,
   output logic [7:0]              io_addr,
   output logic [3:0]              io_be,
   output logic [31:0]             io_wdata,
   input  logic                    io_ack,
   input  logic [31:0]             io_rdata
);

   localparam int          RAM_WORDS = 1 << RAM_WORDS_LOG;
   localparam logic [32:0] RAM_SPAN  = 33'd4 << RAM_WORDS_LOG;
   localparam logic [32:0] ROM_SPAN  = 33'd1 << IM_BYTES_LOG;
   localparam logic [23:0] IO_PAGE   = IO_BASE[31:8];
   localparam logic [7:0]  WAIT_LAST = 8'(IO_TIMEOUT - 1);

   localparam logic [1:0] FLT_OK  = 2'd0;
   localparam logic [1:0] FLT_MIS = 2'd1;
   localparam logic [1:0] FLT_ACC = 2'd2;
   localparam logic [1:0] FLT_TMO = 2'd3;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_IO_WAIT = 1'b1
   } state_t;

   state_t                     state_r, state_s;
   logic [7:0]                 wait_cnt_r;
   logic [31:0]                im_do_r, dm_do_r, io_wdata_r;
   logic                       dm_valid_r, dm_stall_r, io_req_r, io_we_r;
   logic [1:0]                 dm_fault_r;
   logic [7:0]                 io_addr_r;
   logic [3:0]                 io_be_r;
   logic [1:0]                 off_r, size_r;
   logic                       sgn_r;

   logic                       accept_s, misal_s, in_ram_s, in_io_s, in_rom_s;
   logic [1:0]                 fault_s;
   logic [32:0]                ram_off_s;
   logic [RAM_WORDS_LOG-1:0]   ram_idx_s;
   logic [3:0]                 be_s;
   logic [31:0]                wdata_s, ram_rd_s;
   logic                       ram_we_s, io_start_s, io_done_s, io_tmo_s;

   logic [7:0]                 ram_bank_r [4][RAM_WORDS];

   // Shift the addressed lanes down to bit 0 and zero/sign-extend them.
   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = 8'h00;
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'd0:    r = {{24{sgn & b[7]}}, b};
         2'd1:    r = {{16{sgn & h[15]}}, h};
         2'd2:    r = word;
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   assign im_addr_out = im_addr[IM_BYTES_LOG-1:2];
   assign accept_s    = dm_req & ~dm_stall_r;

   // Address decode: region membership and word index within RAM.
   always_comb begin
      ram_off_s = {1'b0, dm_addr} - {1'b0, RAM_BASE};
      in_ram_s  = (ram_off_s < RAM_SPAN);
      in_io_s   = (dm_addr[31:8] == IO_PAGE);
      in_rom_s  = ({1'b0, dm_addr} < ROM_SPAN);
      ram_idx_s = ram_off_s[RAM_WORDS_LOG+1:2];
   end

   // Fault classification; misalignment outranks access faults.
   always_comb begin
      misal_s = 1'b0;
      case (dm_size)
         2'd0:    misal_s = 1'b0;
         2'd1:    misal_s = dm_addr[0];
         2'd2:    misal_s = |dm_addr[1:0];
         default: misal_s = 1'b1;
      endcase
      if (misal_s) begin
         fault_s = FLT_MIS;
      end else if (in_rom_s || !(in_ram_s || in_io_s)) begin
         fault_s = FLT_ACC;
      end else begin
         fault_s = FLT_OK;
      end
   end

   // Byte enables and lane-replicated store data from size and low address bits.
   always_comb begin
      be_s    = 4'b0000;
      wdata_s = dm_di;
      case (dm_size)
         2'd0: begin
            be_s    = 4'b0001 << dm_addr[1:0];
            wdata_s = {4{dm_di[7:0]}};
         end
         2'd1: begin
            be_s    = dm_addr[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{dm_di[15:0]}};
         end
         2'd2: begin
            be_s    = 4'b1111;
            wdata_s = dm_di;
         end
         default: begin
            be_s    = 4'b0000;
            wdata_s = dm_di;
         end
      endcase
   end

   assign ram_we_s = accept_s & dm_we & in_ram_s & (fault_s == FLT_OK);
   assign ram_rd_s = {ram_bank_r[3][ram_idx_s], ram_bank_r[2][ram_idx_s],
                      ram_bank_r[1][ram_idx_s], ram_bank_r[0][ram_idx_s]};

   // Byte-lane RAM write port; contents intentionally survive reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (ram_we_s && be_s[b]) begin
            ram_bank_r[b][ram_idx_s] <= wdata_s[8*b +: 8];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next state: start an I/O access, finish it on ack, or give up on timeout.
   always_comb begin
      state_s    = state_r;
      io_start_s = 1'b0;
      io_done_s  = 1'b0;
      io_tmo_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && in_io_s && (fault_s == FLT_OK)) begin
               io_start_s = 1'b1;
               state_s    = ST_IO_WAIT;
            end else begin
               state_s    = ST_IDLE;
            end
         end
         ST_IO_WAIT: begin
            if (io_ack) begin
               io_done_s = 1'b1;
               state_s   = ST_IDLE;
            end else if (wait_cnt_r == WAIT_LAST) begin
               io_tmo_s  = 1'b1;
               state_s   = ST_IDLE;
            end else begin
               state_s   = ST_IO_WAIT;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Registered datapath: fetch pass-through, responses and I/O bus outputs.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         im_do_r    <= 32'h0000_0000;
         dm_do_r    <= 32'h0000_0000;
         dm_valid_r <= 1'b0;
         dm_fault_r <= FLT_OK;
         dm_stall_r <= 1'b0;
         io_req_r   <= 1'b0;
         io_we_r    <= 1'b0;
         io_addr_r  <= 8'h00;
         io_be_r    <= 4'b0000;
         io_wdata_r <= 32'h0000_0000;
         wait_cnt_r <= 8'd0;
         off_r      <= 2'd0;
         size_r     <= 2'd0;
         sgn_r      <= 1'b0;
      end else begin
         im_do_r    <= im_data;
         dm_valid_r <= 1'b0;
         dm_fault_r <= FLT_OK;
         if (io_start_s) begin
            io_req_r   <= 1'b1;
            dm_stall_r <= 1'b1;
            io_we_r    <= dm_we;
            io_addr_r  <= dm_addr[7:0];
            io_be_r    <= be_s;
            io_wdata_r <= wdata_s;
            off_r      <= dm_addr[1:0];
            size_r     <= dm_size;
            sgn_r      <= dm_signed;
            wait_cnt_r <= 8'd0;
         end else if (io_done_s) begin
            io_req_r   <= 1'b0;
            dm_stall_r <= 1'b0;
            dm_valid_r <= 1'b1;
            dm_do_r    <= io_we_r ? 32'h0000_0000 : load_extract(io_rdata, off_r, size_r, sgn_r);
         end else if (io_tmo_s) begin
            io_req_r   <= 1'b0;
            dm_stall_r <= 1'b0;
            dm_valid_r <= 1'b1;
            dm_fault_r <= FLT_TMO;
            dm_do_r    <= 32'h0000_0000;
         end else if (state_r == ST_IO_WAIT) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
         end else if (accept_s) begin
            dm_valid_r <= 1'b1;
            dm_fault_r <= fault_s;
            // Faulted accesses and stores report zero data.
            if ((fault_s != FLT_OK) || dm_we) begin
               dm_do_r <= 32'h0000_0000;
            end else begin
               dm_do_r <= load_extract(ram_rd_s, dm_addr[1:0], dm_size, dm_signed);
            end
         end
      end
   end

   assign im_do    = im_do_r;
   assign dm_do    = dm_do_r;
   assign dm_valid = dm_valid_r;
   assign dm_fault = dm_fault_r;
   assign dm_stall = dm_stall_r;
   assign io_req   = io_req_r;
   assign io_we    = io_we_r;
   assign io_addr  = io_addr_r;
   assign io_be    = io_be_r;
   assign io_wdata = io_wdata_r;

endmodule

// File: tb/tb_dmem_mmu_hs.sv
// Self-checking bench for dmem_mmu_hs: byte-level memory model, response
// scoreboard keyed by cycle, and directed RAM / fault / I/O / reset scenarios.
module tb_dmem_mmu_hs;
   localparam logic [31:0] RAM_BASE      = 32'h1000_0000;
   localparam int          RAM_WORDS_LOG = 8;
   localparam logic [31:0] IO_BASE       = 32'h8000_0000;
   localparam int          IM_BYTES_LOG  = 12;
   localparam int          IO_TIMEOUT    = 15;

   logic        clk = 1'b0;
   logic        resetb;
   logic [31:0] im_addr, im_data, im_do;
   logic [9:0]  im_addr_out;
   logic        dm_req, dm_we, dm_signed;
   logic [31:0] dm_addr, dm_di, dm_do;
   logic [1:0]  dm_size, dm_fault;
   logic        dm_valid, dm_stall;
   logic        io_req, io_we, io_ack;
   logic [7:0]  io_addr;
   logic [3:0]  io_be;
   logic [31:0] io_wdata, io_rdata;

   dmem_mmu_hs #(
      .RAM_BASE(RAM_BASE), .RAM_WORDS_LOG(RAM_WORDS_LOG), .IO_BASE(IO_BASE),
      .IM_BYTES_LOG(IM_BYTES_LOG), .IO_TIMEOUT(IO_TIMEOUT)
   ) dut (
      .clk(clk), .resetb(resetb), .im_addr(im_addr), .im_addr_out(im_addr_out),
      .im_data(im_data), .im_do(im_do), .dm_req(dm_req), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_size(dm_size), .dm_signed(dm_signed), .dm_di(dm_di),
      .dm_do(dm_do), .dm_valid(dm_valid), .dm_fault(dm_fault), .dm_stall(dm_stall),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_be(io_be),
      .io_wdata(io_wdata), .io_ack(io_ack), .io_rdata(io_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   typedef struct {
      int          cyc;
      logic [1:0]  fault;
      bit          chk_do;
      logic [31:0] dval;
   } rsp_t;

   rsp_t        rq[$];
   int          io_lo = -1, io_hi = -1;
   logic [7:0]  e_io_addr;
   logic [3:0]  e_io_be;
   logic        e_io_we;
   logic [31:0] e_io_wdata;
   bit          chk_en = 1'b0;
   logic [31:0] im_prev;
   logic [7:0]  mem [bit [31:0]];

   function automatic logic [31:0] extend(input logic [31:0] raw, input int nb, input bit sgn);
      logic [31:0] mask, v;
      if (nb >= 4) return raw;
      mask = (32'd1 << (8 * nb)) - 32'd1;
      v = raw & mask;
      if (sgn && raw[8 * nb - 1]) v = v | ~mask;
      return v;
   endfunction

   function automatic bit is_ram(input logic [31:0] addr);
      longint a;
      a = longint'(addr);
      return (a >= longint'(RAM_BASE)) && (a < longint'(RAM_BASE) + 4 * (1 << RAM_WORDS_LOG));
   endfunction

   function automatic logic [1:0] classify(input logic [31:0] addr, input logic [1:0] size);
      longint a;
      a = longint'(addr);
      if (size == 2'd3) return 2'd1;
      if ((addr & ((32'd1 << size) - 32'd1)) != 32'd0) return 2'd1;
      if (a < (longint'(1) << IM_BYTES_LOG)) return 2'd2;
      if (is_ram(addr)) return 2'd0;
      if ((a >= longint'(IO_BASE)) && (a < longint'(IO_BASE) + 256)) return 2'd0;
      return 2'd2;
   endfunction

   // Per-cycle comparison against the scoreboard and the I/O window model.
   always @(negedge clk) begin
      if (chk_en) begin
         if (rq.size() > 0 && rq[0].cyc == cyc) begin
            chk("dm_valid", dm_valid, 1);
            chk("dm_fault", dm_fault, rq[0].fault);
            if (rq[0].chk_do) chk("dm_do", dm_do, rq[0].dval);
            void'(rq.pop_front());
         end else begin
            chk("dm_valid_idle", dm_valid, 0);
         end
         chk("dm_stall", dm_stall, (cyc >= io_lo && cyc < io_hi));
         chk("io_req", io_req, (cyc >= io_lo && cyc < io_hi));
         if (cyc >= io_lo && cyc < io_hi) begin
            chk("io_addr", io_addr, e_io_addr);
            chk("io_be", io_be, e_io_be);
            chk("io_we", io_we, e_io_we);
            chk("io_wdata", io_wdata, e_io_wdata);
         end
         chk("im_do", im_do, im_prev);
         chk("im_addr_out", im_addr_out, im_addr[11:2]);
      end
   end

   always @(posedge clk) im_prev <= im_data;

   initial begin
      im_data = 32'h0;
      im_addr = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         im_data = $urandom;
         im_addr = $urandom;
      end
   end

   // RAM or faulting access: one request cycle, response expected at the accepting edge + 0.
   task automatic issue(input bit we, input logic [31:0] addr, input logic [1:0] size,
                        input bit sgn, input logic [31:0] di, output logic [31:0] mval);
      rsp_t        r;
      logic [1:0]  f;
      logic [31:0] raw;
      int          nb;
      f  = classify(addr, size);
      nb = 1 << size;
      r.cyc = cyc + 1; r.fault = f; r.chk_do = 1'b1; r.dval = 32'h0;
      mval = 32'h0;
      if (f == 2'd0 && is_ram(addr)) begin
         if (we) begin
            for (int i = 0; i < nb; i++) mem[32'(addr + i)] = di[8*i +: 8];
            r.chk_do = 1'b0;
         end else begin
            raw = 32'h0;
            for (int i = 0; i < nb; i++)
               raw = raw | (32'(mem.exists(32'(addr + i)) ? mem[32'(addr + i)] : 8'h00) << (8 * i));
            mval = extend(raw, nb, sgn);
            r.dval = mval;
         end
      end
      rq.push_back(r);
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_size = size; dm_signed = sgn; dm_di = di;
      @(posedge clk);
      #1;
      dm_req = 1'b0;
   endtask

   // I/O access; d > 0 acks in the d-th cycle of io_req, d == 0 never acks (late ack afterwards).
   task automatic io_txn(input bit we, input logic [31:0] addr, input logic [1:0] size, input bit sgn,
                         input logic [31:0] di, input int d, input logic [31:0] rdata,
                         output logic [31:0] mval);
      rsp_t r;
      int   acc, nb, off;
      acc = cyc + 1;
      nb  = 1 << size;
      off = int'(addr[1:0]);
      e_io_addr = addr[7:0];
      e_io_we   = we;
      e_io_be   = 4'(((1 << nb) - 1) << off);
      for (int l = 0; l < 4; l++) e_io_wdata[8*l +: 8] = di[8*((l + 4 - off) % nb) +: 8];
      io_lo = acc;
      io_hi = (d > 0) ? acc + d : acc + IO_TIMEOUT;
      mval = extend(rdata >> (8 * off), nb, sgn);
      r.cyc = io_hi; r.fault = (d > 0) ? 2'd0 : 2'd3; r.chk_do = (d > 0) && !we; r.dval = mval;
      rq.push_back(r);
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_size = size; dm_signed = sgn; dm_di = di;
      @(posedge clk);
      #1;
      // A request presented while stalled must be ignored.
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = RAM_BASE; dm_size = 2'd2;
      if (d > 0) begin
         repeat (d - 1) begin @(posedge clk); #1; end
         dm_req = 1'b0; io_ack = 1'b1; io_rdata = rdata;
         @(posedge clk);
         #1;
         io_ack = 1'b0; io_rdata = 32'hA5A5_5A5A;
      end else begin
         repeat (IO_TIMEOUT - 1) begin @(posedge clk); #1; end
         dm_req = 1'b0;
         @(posedge clk);
         #1;
         io_ack = 1'b1; io_rdata = rdata;
         @(posedge clk);
         #1;
         io_ack = 1'b0; io_rdata = 32'hA5A5_5A5A;
         repeat (2) begin @(posedge clk); #1; end
      end
   endtask

   logic [31:0] v;

   initial begin
      resetb = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_size = 2'd0;
      dm_signed = 1'b0; dm_di = 32'h0; io_ack = 1'b0; io_rdata = 32'hA5A5_5A5A;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_im_do", im_do, 32'h0);       chk("rst_dm_do", dm_do, 32'h0);
      chk("rst_dm_valid", dm_valid, 0);     chk("rst_dm_fault", dm_fault, 0);
      chk("rst_dm_stall", dm_stall, 0);     chk("rst_io_req", io_req, 0);
      chk("rst_io_we", io_we, 0);           chk("rst_io_addr", io_addr, 0);
      chk("rst_io_be", io_be, 0);           chk("rst_io_wdata", io_wdata, 0);
      resetb = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      issue(1, 32'h1000_0004, 2, 0, 32'hDEAD_BEEF, v);
      issue(0, 32'h1000_0004, 2, 0, 32'h0, v);
      chk("model_ld_word", v, 32'hDEAD_BEEF);  chk("ld_word_do", dm_do, 32'hDEAD_BEEF);
      issue(1, 32'h1000_0000, 2, 0, 32'h12EF_3456, v);
      issue(1, 32'h1000_0003, 0, 0, 32'h0000_0080, v);
      issue(0, 32'h1000_0003, 0, 1, 32'h0, v);
      chk("model_lb_s", v, 32'hFFFF_FF80);     chk("lb_s_do", dm_do, 32'hFFFF_FF80);
      issue(0, 32'h1000_0003, 0, 0, 32'h0, v);
      chk("model_lb_u", v, 32'h0000_0080);
      issue(0, 32'h1000_0002, 1, 1, 32'h0, v);
      chk("model_lh_s", v, 32'hFFFF_80EF);     chk("lh_s_do", dm_do, 32'hFFFF_80EF);
      issue(0, 32'h1000_0000, 1, 0, 32'h0, v);
      chk("model_lh_u", v, 32'h0000_3456);
      issue(1, 32'h1000_03FC, 2, 0, 32'hCAFE_F00D, v);
      issue(0, 32'h1000_03FC, 2, 0, 32'h0, v);
      chk("model_last_word", v, 32'hCAFE_F00D);

      issue(0, 32'h1000_0002, 2, 0, 32'h0, v);
      chk("mis_word_fault", dm_fault, 2'd1);
      issue(1, 32'h1000_0006, 2, 0, 32'hFFFF_FFFF, v);
      issue(0, 32'h1000_0004, 2, 0, 32'h0, v);
      chk("no_write_on_fault", dm_do, 32'hDEAD_BEEF);
      issue(1, 32'h0000_0100, 2, 0, 32'h1111_1111, v);
      chk("rom_store_fault", dm_fault, 2'd2);
      issue(0, 32'h2000_0000, 2, 0, 32'h0, v);
      chk("unmapped_fault", dm_fault, 2'd2);
      issue(0, 32'h1000_0400, 2, 0, 32'h0, v);
      issue(0, 32'h8000_0100, 0, 0, 32'h0, v);
      issue(0, 32'h1000_0001, 1, 0, 32'h0, v);
      issue(1, 32'h1000_0000, 3, 0, 32'h0, v);
      issue(0, 32'h0000_0101, 1, 0, 32'h0, v);
      chk("mis_beats_rom", dm_fault, 2'd1);
      issue(0, 32'h8000_0001, 1, 0, 32'h0, v);
      @(posedge clk);
      #1;

      io_txn(1, 32'h8000_0012, 1, 0, 32'h0000_1234, 3, 32'h0, v);
      chk("model_io_addr", e_io_addr, 8'h12);
      chk("model_io_be", e_io_be, 4'b1100);
      chk("model_io_wdata", e_io_wdata, 32'h1234_1234);
      chk("io_st_fault", dm_fault, 2'd0);
      io_txn(0, 32'h8000_0022, 1, 1, 32'h0, 5, 32'h8765_4321, v);
      chk("model_io_lh_s", v, 32'hFFFF_8765);  chk("io_lh_s_do", dm_do, 32'hFFFF_8765);
      io_txn(0, 32'h8000_00FD, 0, 0, 32'h0, 1, 32'h0000_C300, v);
      chk("model_io_lb_u", v, 32'h0000_00C3);
      io_txn(1, 32'h8000_0041, 0, 0, 32'h0000_005A, 15, 32'h0, v);
      chk("model_io_byte_wd", e_io_wdata, 32'h5A5A_5A5A);
      chk("model_io_byte_be", e_io_be, 4'b0010);
      io_txn(0, 32'h8000_0000, 2, 0, 32'h0, 0, 32'h1357_9BDF, v);
      issue(0, 32'h1000_03FC, 2, 0, 32'h0, v);
      issue(0, 32'h1000_0004, 2, 0, 32'h0, v);

      // Reset in the middle of an I/O wait.
      chk_en = 1'b0;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8000_0004; dm_size = 2'd2;
      @(posedge clk);
      #1;
      dm_req = 1'b0;
      chk("mid_io_req", io_req, 1);
      chk("mid_io_stall", dm_stall, 1);
      repeat (3) @(posedge clk);
      #2;
      resetb = 1'b0;
      #1;
      chk("rst_async_io_req", io_req, 0);
      chk("rst_async_stall", dm_stall, 0);
      chk("rst_async_valid", dm_valid, 0);
      rq.delete();
      io_lo = -1; io_hi = -1;
      @(posedge clk);
      #1;
      resetb = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      issue(0, 32'h1000_0004, 2, 0, 32'h0, v);
      chk("post_rst_valid", dm_valid, 1);
      chk("post_rst_do", dm_do, 32'hDEAD_BEEF);
      repeat (3) @(posedge clk);
      #1;
      if (rq.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL pending_responses: %0d left, expected 0", rq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
